apple_gen: RTL

Apple generator and eat detector sitting directly upstream of the `snake` block. It watches the snake head on each game tick, issues the one-cycle `apple_eaten` pulse that grows the snake, and picks a new apple cell from a free-running LFSR. It checks each candidate serially against the snake body arrays, one segment per clock, so a new apple never lands on the snake. The current position drives the snake block's `apple_x`/`apple_y` inputs.

---
 rtl/apple_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/apple_gen.sv
// Apple placement and eat detection for the snake game: LFSR-driven candidates checked serially against the body.
// Optional sequential sweep fallback is enabled with `define APPLE_GEN_SWEEP_EN.
module apple_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 32,
  parameter logic [3:0]  RESET_X   = 4'd12,
  parameter logic [3:0]  RESET_Y   = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       collision,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  input  logic [7:0] snake_length,
  input  logic [3:0] x [0:127],
  input  logic [3:0] y [0:127],
  output logic [3:0] apple_x,
  output logic [3:0] apple_y,
  output logic       apple_eaten,
  output logic       apple_valid
);

`ifdef APPLE_GEN_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {HOLD, PICK, SCAN, PLACE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [7:0]  cand_reg, cand_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  tries_reg, tries_next;
  logic        sweep_reg, sweep_next;
  logic [3:0]  apple_x_next, apple_y_next;
  logic        eaten_next, valid_next;
  logic [7:0]  len_eff;
  logic        hit, head_hit, sweep_now, scan_done;

  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);
  assign len_eff   = (snake_length > 8'd128) ? 8'd128 : snake_length;
  assign scan_done = (idx_reg >= len_eff);
  // idx reaches 128 only when scan_done already masks the compare
  assign hit       = ({x[idx_reg[6:0]], y[idx_reg[6:0]]} == cand_reg);
  assign head_hit  = enable && !collision && (head_x == apple_x) && (head_y == apple_y);
  assign sweep_now = SWEEP_EN && (sweep_reg || (tries_reg == 8'(MAX_TRIES)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= HOLD;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!collision) begin
      case (state_reg)
        HOLD:    if (head_hit) state_next = PICK;
        PICK:    state_next = SCAN;
        SCAN: begin
          if (scan_done) state_next = PLACE;
          else if (hit)  state_next = PICK;
        end
        PLACE:   state_next = HOLD;
        default: state_next = HOLD;
      endcase
    end
  end

  always_comb begin
    cand_next    = cand_reg;
    idx_next     = idx_reg;
    tries_next   = tries_reg;
    sweep_next   = sweep_reg;
    apple_x_next = apple_x;
    apple_y_next = apple_y;
    valid_next   = apple_valid;
    eaten_next   = 1'b0;
    if (!collision) begin
      case (state_reg)
        HOLD: eaten_next = head_hit;
        PICK: begin
          cand_next  = sweep_now ? cand_reg + 8'd1 : lfsr_reg[7:0];
          sweep_next = sweep_now;
          idx_next   = 8'd0;
          tries_next = (tries_reg == 8'hFF) ? tries_reg : tries_reg + 8'd1;
          valid_next = 1'b0;
        end
        SCAN: begin
          if (!scan_done && !hit) idx_next = idx_reg + 8'd1;
        end
        PLACE: begin
          apple_x_next = cand_reg[7:4];
          apple_y_next = cand_reg[3:0];
          valid_next   = 1'b1;
          tries_next   = 8'd0;
          sweep_next   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg    <= SEED;
      cand_reg    <= 8'd0;
      idx_reg     <= 8'd0;
      tries_reg   <= 8'd0;
      sweep_reg   <= 1'b0;
      apple_x     <= RESET_X;
      apple_y     <= RESET_Y;
      apple_eaten <= 1'b0;
      apple_valid <= 1'b1;
    end else begin
      lfsr_reg    <= lfsr_next;
      cand_reg    <= cand_next;
      idx_reg     <= idx_next;
      tries_reg   <= tries_next;
      sweep_reg   <= sweep_next;
      apple_x     <= apple_x_next;
      apple_y     <= apple_y_next;
      apple_eaten <= eaten_next;
      apple_valid <= valid_next;
    end
  end

endmodule
